div_ctrl: RTL

- Multi-cycle 32-bit divide sequencer serving the execute stage for DIV/DIVU.
- Implements a radix-2 restoring divider (one quotient bit per cycle) driven by a four-state FSM.
- Execute stage issues start_i, drives its stallreq from busy_o/ready_o, and consumes the 64-bit {remainder, quotient} result for HI/LO.
- annul_i lets pipeline control kill an in-flight divide on flush.

---
 rtl/div_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divide sequencer for DIV/DIVU.
// Produces {remainder, quotient} after DATA_W+1 cycles, or after one cycle for a zero divisor.
module div_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     rem_r;
  logic [DATA_W-1:0]     dvd_r;
  logic [DATA_W-1:0]     dvs_r;
  logic                  sgn_r;
  logic                  s1_r;
  logic                  s2_r;

  logic [DATA_W:0]       shifted;
  logic signed [DATA_W:0] trial;

  // Magnitude of a two's complement operand; the most negative value maps onto itself.
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic en);
    return (en && x[DATA_W-1]) ? -x : x;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  always_comb begin
    shifted = {rem_r, dvd_r[DATA_W-1]};
    trial   = $signed(shifted - {1'b0, dvs_r});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem_r    <= '0;
      dvd_r    <= '0;
      dvs_r    <= '0;
      sgn_r    <= 1'b0;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          busy_o   <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            sgn_r  <= signed_div_i;
            s1_r   <= opdata1_i[DATA_W-1];
            s2_r   <= opdata2_i[DATA_W-1];
            busy_o <= 1'b1;
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              dvd_r <= mag(opdata1_i, signed_div_i);
              dvs_r <= mag(opdata2_i, signed_div_i);
              rem_r <= '0;
              cnt   <= '0;
            end
          end
        end
        BYZERO: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state <= FREE;
          end else begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        ON: begin
          if (annul_i) begin
            state  <= FREE;
            busy_o <= 1'b0;
          end else if (cnt == LAST) begin
            state    <= END;
            busy_o   <= 1'b0;
            ready_o  <= 1'b1;
            result_o <= {cond_neg(rem_r, sgn_r && s1_r),
                         cond_neg(dvd_r, sgn_r && (s1_r ^ s2_r))};
          end else begin
            // Quotient bits shift into the vacated low end of the dividend register.
            if (trial >= 0) begin
              rem_r <= trial[DATA_W-1:0];
              dvd_r <= {dvd_r[DATA_W-2:0], 1'b1};
            end else begin
              rem_r <= shifted[DATA_W-1:0];
              dvd_r <= {dvd_r[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        END: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule
